// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared PS/2 command constants, transmitter state and error codes.
package ps2_host_tx_pkg;

   localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      START,
      SEND,
      ACK,
      RELEASE,
      FAIL
   } ps2_tx_state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_TIMEOUT = 2'd1,
      ERR_NACK    = 2'd2
   } ps2_err_t;

   // Host-to-device frame after the start bit, bit 0 goes out first: data, odd parity, stop.
   function automatic logic [9:0] ps2_frame(input logic [7:0] data);
      return {1'b1, ~^data, data};
   endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// ps2_line_filter: two-flop synchroniser, consecutive-sample glitch filter and
// falling-edge strobe for one PS/2 pad. Reusable by the mouse receiver.
module ps2_line_filter #(
   parameter int FILTER_CYCLES = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic line_raw,
   output logic level,
   output logic fall
);

   localparam int               CNT_W    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

   logic [1:0]       sync;
   logic [CNT_W-1:0] run_cnt;

   // Synchronise the pad, then accept a new level only after FILTER_CYCLES differing samples in a row.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync    <= 2'b11;
         level   <= 1'b1;
         run_cnt <= '0;
         fall    <= 1'b0;
      end else begin
         sync <= {sync[0], line_raw};
         fall <= 1'b0;
         if (sync[1] == level) begin
            run_cnt <= '0;
         end else if (run_cnt == CNT_LAST) begin
            level   <= sync[1];
            run_cnt <= '0;
            fall    <= level;
         end else begin
            run_cnt <= run_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte host-to-device on the open-drain PS/2 lines
// and reports done (device ACK) or error (timeout / NACK) to the init sequencer.
//
// state   | meaning
// IDLE    | lines released, cmdReady high, waiting for a command
// INHIBIT | host holds PS2_CLK low to claim the bus
// START   | data held low (start bit), clock released, timeout armed
// SEND    | present next frame bit on each device clock fall
// ACK     | stop bit out; sample device ACK on the next clock fall
// RELEASE | wait for the device to release both lines, then pulse done
// FAIL    | error pulse showing, lines released, back to IDLE
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int CLK_HZ        = 50_000_000,
   parameter int INHIBIT_US    = 100,
   parameter int TIMEOUT_US    = 15000,
   parameter int FILTER_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] cmdData,
   input  logic       cmdValid,
   output logic       cmdReady,
   input  logic       ps2ClkIn,
   input  logic       ps2DatIn,
   output logic       ps2ClkPullLow,
   output logic       ps2DatPullLow,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [1:0] errCode
);

   localparam longint INH_CYC_L = (longint'(INHIBIT_US) * longint'(CLK_HZ)) / 1_000_000;
   localparam longint TMO_CYC_L = (longint'(TIMEOUT_US) * longint'(CLK_HZ)) / 1_000_000;
   localparam int     INH_CYC   = int'(INH_CYC_L);
   localparam int     TMO_CYC   = int'(TMO_CYC_L);
   localparam int     INH_W     = $clog2(INH_CYC);
   localparam int     TMO_W     = $clog2(TMO_CYC);

   localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INH_CYC - 1);
   // Two cycles are spent loading the counter and registering the expiry decision,
   // so error lands exactly TMO_CYC cycles after START or the last clock fall.
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYC - 2);

   ps2_tx_state_t    state;
   logic [9:0]       frame_sr;
   logic [3:0]       bit_cnt;
   logic [INH_W-1:0] inh_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic             clk_level;
   logic             clk_fall;
   logic             dat_level;
   logic             unused_dat_fall;
   logic             tmo_expired;

   ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
      .clk      (clk),
      .rst      (rst),
      .line_raw (ps2ClkIn),
      .level    (clk_level),
      .fall     (clk_fall)
   );

   ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_dat_filter (
      .clk      (clk),
      .rst      (rst),
      .line_raw (ps2DatIn),
      .level    (dat_level),
      .fall     (unused_dat_fall)
   );

   assign tmo_expired = (tmo_cnt == '0) && !clk_fall;

   // Transfer sequencer; every output is registered here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         frame_sr      <= '0;
         bit_cnt       <= '0;
         inh_cnt       <= '0;
         tmo_cnt       <= '0;
         cmdReady      <= 1'b1;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         errCode       <= ERR_NONE;
         ps2ClkPullLow <= 1'b0;
         ps2DatPullLow <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;

         // Device-activity watchdog: any clock fall restarts it; START arms it below.
         if (clk_fall) begin
            tmo_cnt <= TMO_LOAD;
         end else if (tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
         end

         case (state)
            IDLE: begin
               if (cmdValid && cmdReady) begin
                  frame_sr      <= ps2_frame(cmdData);
                  errCode       <= ERR_NONE;
                  busy          <= 1'b1;
                  cmdReady      <= 1'b0;
                  ps2ClkPullLow <= 1'b1;
                  inh_cnt       <= INH_LOAD;
                  state         <= INHIBIT;
               end
            end
            INHIBIT: begin
               if (inh_cnt == '0) begin
                  ps2ClkPullLow <= 1'b0;
                  ps2DatPullLow <= 1'b1;
                  state         <= START;
               end else begin
                  inh_cnt <= inh_cnt - 1'b1;
               end
            end
            START: begin
               tmo_cnt <= TMO_LOAD;
               bit_cnt <= '0;
               state   <= SEND;
            end
            SEND: begin
               if (clk_fall) begin
                  ps2DatPullLow <= ~frame_sr[0];
                  frame_sr      <= {1'b0, frame_sr[9:1]};
                  bit_cnt       <= bit_cnt + 1'b1;
                  if (bit_cnt == 4'd9) begin
                     state <= ACK;
                  end
               end else if (tmo_expired) begin
                  errCode       <= ERR_TIMEOUT;
                  error         <= 1'b1;
                  ps2DatPullLow <= 1'b0;
                  state         <= FAIL;
               end
            end
            ACK: begin
               if (clk_fall) begin
                  if (dat_level) begin
                     errCode <= ERR_NACK;
                     error   <= 1'b1;
                     state   <= FAIL;
                  end else begin
                     state <= RELEASE;
                  end
               end else if (tmo_expired) begin
                  errCode <= ERR_TIMEOUT;
                  error   <= 1'b1;
                  state   <= FAIL;
               end
            end
            RELEASE: begin
               if (done) begin
                  busy     <= 1'b0;
                  cmdReady <= 1'b1;
                  state    <= IDLE;
               end else if (clk_level && dat_level) begin
                  done <= 1'b1;
               end else if (tmo_expired) begin
                  errCode <= ERR_TIMEOUT;
                  error   <= 1'b1;
                  state   <= FAIL;
               end
            end
            FAIL: begin
               ps2ClkPullLow <= 1'b0;
               ps2DatPullLow <= 1'b0;
               busy          <= 1'b0;
               cmdReady      <= 1'b1;
               state         <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 command transmitter. It is the transmit counterpart to the existing receive-only PS/2 mouse interface.
- Sends one command byte, e.g. 0xF4 "enable data reporting", to the mouse on the shared PS2_CLK/PS2_DAT open-drain lines.
- Sits beside the mouse receiver in the DE1 top level on CLOCK_50.
- Reports completion, device ACK, or failure back to a small init sequencer.

Parameters:
- CLK_HZ, 50_000_000: system clock frequency.
- INHIBIT_US, 100: time the host holds CLK low before the start bit.
- TIMEOUT_US, 15000: maximum wait for any expected device clock edge or ACK, measured from the last event.
- FILTER_CYCLES, 8: number of consecutive equal samples needed to accept a PS/2 line level.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- cmdData  in  8  command byte to send.
- cmdValid  in  1  request to send cmdData.
- cmdReady  out  1  high only in IDLE; a transfer starts on cmdValid && cmdReady.
- ps2ClkIn  in  1  raw PS2_CLK pad level.
- ps2DatIn  in  1  raw PS2_DAT pad level.
- ps2ClkPullLow  out  1  1 means drive PS2_CLK to 0; 0 means high-Z.
- ps2DatPullLow  out  1  1 means drive PS2_DAT to 0; 0 means high-Z.
- busy  out  1  high from acceptance until done/error.
- done  out  1  one-cycle pulse: byte sent and device ACK seen.
- error  out  1  one-cycle pulse on failure.
- errCode  out  2  valid when error=1: 1 = timeout, 2 = NACK (data high at ACK time); held until the next accept.

Behaviour:
- Reset (asynchronous, rst=0):
  - State goes to IDLE; both pull-low outputs go to 0, so the lines are released immediately.
  - cmdReady=1 after reset release; busy=0, done=0, error=0, errCode=0.
  - Counters and shift register are cleared.
  - A reset mid-transfer abandons the byte with no done/error pulse.
- Line conditioning:
  - Each raw input is double-flopped, then filtered: the level changes only after FILTER_CYCLES equal samples.
  - clkFall = filtered clock transitions from 1 to 0 (one-cycle strobe).
- Frame:
  - Shift register holds {stop=1, parity, data[7:0]}.
  - Parity is odd: parity = ~^cmdData.
  - Bits are sent LSB first.
- FSM:
  - IDLE: on accept, latch the frame, set busy=1, cmdReady=0, go to INHIBIT.
  - INHIBIT: ps2ClkPullLow=1 for INHIBIT_US*CLK_HZ/1e6 cycles (5000 at defaults), then go to START.
  - START, one cycle: ps2DatPullLow=1 (start bit 0); release clock; load the timeout counter; go to SEND with bitCnt=0.
  - SEND:
    - On each clkFall, present the next frame bit: ps2DatPullLow = ~bit; bitCnt increments.
    - bitCnt 0-7 are data, 8 is parity, 9 is stop (data released).
    - After the clkFall that presents stop (bitCnt reaches 10), go to ACK.
  - ACK: on the next clkFall, sample filtered data.
    - Data 0 goes to RELEASE.
    - Data 1 sets errCode=2 and goes to FAIL.
  - RELEASE: wait until filtered clock=1 and data=1, then pulse done for one cycle and go to IDLE.
  - FAIL: pulse error for one cycle, release both lines, go to IDLE.
- Timeout:
  - In SEND, ACK and RELEASE, the counter reloads on every clkFall.
  - Expiry (TIMEOUT_US*CLK_HZ/1e6 cycles, 750000 at defaults) sets errCode=1 and goes to FAIL.
- Handshake:
  - cmdValid while busy is ignored and not queued.
  - done and error never assert in the same cycle.
  - cmdReady rises in the cycle after the done/error pulse.
- Safety: ps2ClkPullLow is asserted only in INHIBIT; the device owns the clock at all other times.
- Widths: counters are sized with $clog2 of their maximum cycle count; bitCnt is 4 bits.

Decomposition:
- Shared package (alongside the CCHW package):
  - PS2 command constants: PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4, PS2_CMD_SET_RATE=8'hF3.
  - ps2_tx_state_t enum: IDLE, INHIBIT, START, SEND, ACK, RELEASE, FAIL.
  - ps2_err_t codes.
- Sub-module: ps2_line_filter (synchroniser, glitch filter, falling-edge strobe), instantiated twice. The mouse receiver can share it later.

Test Plan:
- Send 0xF4, with a device model clocking at 12.5 kHz and ACKing:
  - ps2ClkPullLow high for exactly 5000 cycles, then start bit 0.
  - Device samples bits 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - One done pulse; errCode=0.
- Send 0xFF: parity bit 1; device sees eight 1s then parity 1; done pulses.
- Device never clocks after START: error pulses exactly 750000 cycles after START with errCode=1; both pull-lows are 0 afterwards.
- Device leaves data high at the 11th falling edge: error pulses with errCode=2; no done.
- Busy and glitch handling:
  - cmdValid with 0x00 asserted during a 0xF4 transfer is ignored: one frame only, cmdReady=0 throughout.
  - A 3-cycle clock glitch during SEND does not advance bitCnt.
- Reset mid-transfer:
  - rst=0 at bit 4 releases both lines in the same cycle, with no done/error.
  - After release, a new 0xF3 transfer completes normally.
